// File: rtl/svm_r_pkg.sv
// Shared coefficients, widths and FSM encodings for the SVM regressor family.
// The parallel and sequenced regressors both read this single coefficient source.
package svm_r_pkg;

  localparam int NUM_FEAT = 6;
  localparam int ACT_W    = 4;
  localparam int W_W      = 8;
  localparam int OUT_W    = 13;
  localparam int PROD_W   = ACT_W + W_W;
  localparam int IDX_W    = $clog2(NUM_FEAT);
  localparam int IN_W     = NUM_FEAT * ACT_W;

  localparam logic signed [W_W-1:0] WEIGHTS [NUM_FEAT] = '{
    8'sd5, -8'sd61, -8'sd13, 8'sd36, 8'sd88, -8'sd65
  };

  localparam logic signed [OUT_W-1:0] INTERCEPT = 13'sd1063;
  localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(NUM_FEAT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Widen a signed product to the accumulator width.
  function automatic logic signed [OUT_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(OUT_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/svm_r_seq_ctrl_if.sv
// Feature-in / result-out handshake bundle of the sequenced SVM regressor.
interface svm_r_seq_ctrl_if;
  import svm_r_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         inp;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out;
  logic                    busy;

  modport master (
    output in_valid, inp, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, inp, out_ready,
    output in_ready, out_valid, out, busy
  );

endinterface

// File: rtl/svm_r_mac.sv
// Single multiply-accumulate lane: selects feature idx and its weight, multiplies
// unsigned feature by signed weight and adds into the wrapping accumulator.
module svm_r_mac
  import svm_r_pkg::*;
(
  input  logic [IN_W-1:0]         feat,
  input  logic [IDX_W-1:0]        idx,
  input  logic signed [OUT_W-1:0] acc,
  output logic signed [OUT_W-1:0] acc_nxt
);

  logic [ACT_W-1:0]         x_s;
  logic signed [W_W-1:0]    w_s;
  logic signed [PROD_W-1:0] prod_s;

  // Feature / coefficient mux driven by the iteration index
  always_comb begin
    x_s = '0;
    w_s = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      x_s = (idx == IDX_W'(i)) ? feat[i*ACT_W +: ACT_W] : x_s;
      w_s = (idx == IDX_W'(i)) ? WEIGHTS[i] : w_s;
    end
  end

  assign prod_s  = PROD_W'($signed({1'b0, x_s})) * PROD_W'(w_s);
  assign acc_nxt = acc + sext_prod(prod_s);

endmodule

// File: rtl/svm_r_seq_ctrl.sv
// Sequenced SVM regressor: one MAC lane iterated over NUM_FEAT features, with
// valid/ready handshakes on the feature input and the result output.
module svm_r_seq_ctrl
  import svm_r_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  svm_r_seq_ctrl_if.slave   bus
);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]         feat_q, feat_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic signed [OUT_W-1:0] acc_nxt_s;
  logic                    in_ready_s;
  logic                    accept_s;

  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  svm_r_mac u_mac (
    .feat    (feat_q),
    .idx     (idx_q),
    .acc     (acc_q),
    .acc_nxt (acc_nxt_s)
  );

  // Next-state, counter and datapath register logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_d       = out_q;
    feat_d      = feat_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_MAC;
          feat_d  = bus.inp;
          acc_d   = INTERCEPT;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_MAC: begin
        acc_d = acc_nxt_s;
        if (idx_q == IDX_LAST) begin
          state_d     = ST_DONE;
          idx_d       = '0;
          out_d       = acc_nxt_s;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          idx_d       = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        // Retiring the result and accepting the next vector may share one edge
        if (bus.out_ready && bus.in_valid) begin
          state_d     = ST_MAC;
          feat_d      = bus.inp;
          acc_d       = INTERCEPT;
          idx_d       = '0;
          out_valid_d = 1'b0;
          busy_d      = 1'b1;
        end else if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = '0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      feat_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      feat_q      <= feat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_svm_r_seq_ctrl.sv
// Scoreboard bench for svm_r_seq_ctrl: expected results are queued at accept
// and compared when the consumer takes a result.
module tb_svm_r_seq_ctrl;
  import svm_r_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  svm_r_seq_ctrl_if bus_if ();

  svm_r_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   exp_q[$];
  int   acc_step_q[$];
  int   step_no    = 0;
  int   n_results  = 0;
  int   n_acc      = 0;
  logic prev_ov    = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Parallel reference: intercept plus sum of feature*weight, wrapped to 13 bits
  function automatic int golden(input logic [23:0] v);
    int          w [6] = '{5, -61, -13, 36, 88, -65};
    int          s = 1063;
    logic [12:0] r;
    for (int i = 0; i < 6; i++) s += int'(v[i*4 +: 4]) * w[i];
    r = s[12:0];
    return int'($signed(r));
  endfunction

  // One clock: drive at negedge, then observe the handshakes that the next posedge will commit
  task automatic step(input logic iv, input logic [23:0] d, input logic ordy);
    @(negedge clk);
    bus_if.in_valid  = iv;
    bus_if.inp       = d;
    bus_if.out_ready = ordy;
    #1;
    step_no++;
    if (bus_if.out_valid && !prev_ov) begin
      if (acc_step_q.size() == 0) check_val("ov_without_accept", 1, 0);
      else check_val("latency_steps", step_no - acc_step_q.pop_front(), NUM_FEAT + 1);
    end
    prev_ov = bus_if.out_valid;
    if (bus_if.out_valid && bus_if.out_ready) begin
      n_results++;
      if (exp_q.size() == 0) check_val("unexpected_result", 1, 0);
      else check_val("result", int'(bus_if.out), exp_q.pop_front());
    end
    if (bus_if.in_valid && bus_if.in_ready) begin
      exp_q.push_back(golden(d));
      acc_step_q.push_back(step_no);
      n_acc++;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || bus_if.out_valid) && guard < 200) begin
      step(1'b0, 24'h0, 1'b1);
      guard++;
    end
    check_val("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    acc_step_q.delete();
  endtask

  logic [23:0] dir_vec [4] = '{24'h000000, 24'hFFFFFF, 24'h0FF00F, 24'hF00FF0};
  int          dir_exp [4] = '{1063, 913, 2998, -1022};

  initial begin
    int          start;
    int          guard;
    int          held;
    logic [23:0] v;

    bus_if.in_valid  = 1'b0;
    bus_if.inp       = 24'h0;
    bus_if.out_ready = 1'b0;
    #12;
    check_val("rst_out_valid", int'(bus_if.out_valid), 0);
    check_val("rst_out", int'(bus_if.out), 0);
    check_val("rst_busy", int'(bus_if.busy), 0);
    check_val("rst_in_ready", int'(bus_if.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, including the extremes of the result range
    for (int k = 0; k < 4; k++) begin
      step(1'b1, dir_vec[k], 1'b1);
      step(1'b0, 24'h0, 1'b1);
      check_val("busy_in_mac", int'(bus_if.busy), 1);
      drain();
      check_val("dir_out_kept", int'(bus_if.out), dir_exp[k]);
    end

    // Consumer stalls for 20 cycles in DONE
    v = 24'h0FF00F;
    step(1'b1, v, 1'b0);
    guard = 0;
    while (!bus_if.out_valid && guard < 20) begin
      step(1'b0, 24'h0, 1'b0);
      guard++;
    end
    check_val("stall_reached_done", int'(bus_if.out_valid), 1);
    held = int'(bus_if.out);
    check_val("stall_value", held, 2998);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 24'($urandom), 1'b0);
      check_val("stall_out_valid", int'(bus_if.out_valid), 1);
      check_val("stall_out", int'(bus_if.out), held);
      check_val("stall_in_ready", int'(bus_if.in_ready), 0);
    end
    start = n_results;
    step(1'b0, 24'h0, 1'b1);
    step(1'b0, 24'h0, 1'b1);
    check_val("stall_one_transfer", n_results - start, 1);
    check_val("idle_out_valid", int'(bus_if.out_valid), 0);
    check_val("idle_out_kept", int'(bus_if.out), 2998);
    drain();

    // Reset asserted in the middle of MAC
    step(1'b1, 24'hFFFFFF, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 24'h0, 1'b1);
    check_val("pre_abort_busy", int'(bus_if.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", int'(bus_if.out_valid), 0);
    check_val("abort_out", int'(bus_if.out), 0);
    check_val("abort_busy", int'(bus_if.busy), 0);
    exp_q.delete();
    acc_step_q.delete();
    prev_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 24'hF00FF0, 1'b1);
    drain();
    check_val("post_abort_out", int'(bus_if.out), -1022);

    // Back-to-back stream with source and consumer always ready
    start = n_acc;
    guard = 0;
    while (n_acc - start < 50 && guard < 1000) begin
      step(1'b1, 24'($urandom), 1'b1);
      guard++;
    end
    check_val("stream_accepts", n_acc - start, 50);
    start = n_results;
    drain();

    // Random throttling on both sides
    for (int c = 0; c < 1500; c++) begin
      step(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
